wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Producer side of the register-file write port (wr / dst / wd). Merges two result streams into the single per-cycle regfile write.
  - In-order pipeline writeback stream: no backpressure.
  - Long-latency multiply/divide (MDU) stream: valid/ready handshake.
- MDU results queue in a small FIFO and drain into idle writeback slots.
- Also reports pending-write hazards to decode and raises a stall request when the FIFO starves.

Parameters:
- DEPTH, 4, MDU result FIFO entries; power of two, >= 2.
- STARVE_MAX, 8, cycles the FIFO head may wait before stall_req asserts; >= 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_wr  in  1  writeback stage requests a regfile write this cycle.
- pipe_dst  in  5  writeback destination register.
- pipe_data  in  32  writeback data.
- mdu_valid  in  1  MDU result available.
- mdu_dst  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- mdu_ready  out  1  FIFO can accept; equals !full.
- reg_wr  out  1  regfile write enable.
- reg_dst  out  5  regfile write address.
- reg_wd  out  32  regfile write data.
- chk_rs  in  5  decode-stage rs to check.
- chk_rt  in  5  decode-stage rt to check.
- rs_pending  out  1  chk_rs matches a valid FIFO entry; 0 when chk_rs==0.
- rt_pending  out  1  same for chk_rt.
- stall_req  out  1  request one pipeline bubble so the FIFO can drain.
- fifo_count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty: pointers 0, count 0.
  - Starvation counter 0.
  - While rst_n is low: reg_wr=0, mdu_ready=0, stall_req=0, rs_pending=0, rt_pending=0.
  - reg_dst / reg_wd are don't-care while reg_wr=0 and are driven 0.
  - Reset mid-operation discards all queued MDU results silently.
- Write-slot selection: combinational, zero latency.
  - The regfile captures the write on the same clk edge.
  - Priority 1: pipe_wr=1 and pipe_dst!=0 -> reg_wr=1, reg_dst=pipe_dst, reg_wd=pipe_data.
  - Priority 2: otherwise, if the FIFO is non-empty -> reg_wr=1 with the head entry; the head pops at the edge.
  - Otherwise reg_wr=0.
- $0 filtering:
  - Pipe writes to $0 are suppressed; that slot counts as idle, so the FIFO may use it.
  - MDU results with mdu_dst==0 are accepted (handshake completes) but never enqueued.
- Enqueue: on an edge where mdu_valid & mdu_ready & mdu_dst!=0, push {mdu_dst, mdu_data} at the tail.
- Simultaneous push and pop on a non-empty FIFO: count unchanged, both pointers advance.
  - Full FIFO: mdu_ready=0, even if a pop occurs this cycle (no same-cycle pass-through).
  - Empty FIFO: a push and a write in the same cycle never bypass; the pushed entry is written at the earliest on the next cycle.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Ordering:
  - FIFO entries retire in arrival order.
  - The pipeline-vs-MDU ordering to the same register is the hazard unit's responsibility, enforced via the *_pending outputs.
  - rs_pending / rt_pending are combinational compares against all valid entries.
  - An entry popped this cycle still reports pending this cycle.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
  - stall_req = (counter == STARVE_MAX) | full.
  - Pipeline contract: while stall_req=1, the next cycle presents pipe_wr=0 (bubble), which guarantees a pop.
- stall_req must not be gated by mdu_valid.
- Debug print on every asserted reg_wr: "reg:$<dst><=<data>" in hex.

Decomposition:
- Shared package cpu_pkg:
  - REG_AW=5, DATA_W=32, REG_ZERO=5'd0.
  - Typedef wb_req_t {dst, data}, used by this block and by the MDU.
- One sub-module: wb_fifo (parameterised DEPTH, generic push/pop/full/empty/count, exposes entry array and valid mask for the pending compares).
- Arbitration, $0 filter, starvation counter and pending compares stay in wb_write_arbiter.

Test Plan:
- Reset release, idle -> reg_wr=0, mdu_ready=1, fifo_count=0. Then pipe_wr=1, dst=5, data=0xDEADBEEF -> reg_wr=1, reg_dst=5, reg_wd=0xDEADBEEF in the same cycle.
- pipe_wr held 1 with dst=3 while MDU pushes dst=9 (0x11), dst=10 (0x22) -> fifo_count=2, rt_pending=1 for chk_rt=9. Drop pipe_wr -> writes $9=0x11, then $10=0x22 on consecutive cycles; count returns to 0.
- pipe_wr=1 with dst=0 while FIFO holds dst=4 -> reg_wr=1, reg_dst=4 (idle slot used). Separately, mdu_dst=0 with valid=1 -> handshake completes, fifo_count stays 0.
- Keep pipe busy, push DEPTH=4 entries -> mdu_ready=0, stall_req=1. A 5th mdu_valid is held and not lost; after one bubble the pop occurs, then mdu_ready=1 and the held result is accepted.
- One entry queued, pipe busy 8 cycles -> stall_req rises on exactly the 9th cycle (counter == STARVE_MAX), falls the cycle after the pop.
- Assert rst_n=0 asynchronously with 3 entries queued -> outputs clear immediately with no clk edge. After release, fifo_count=0 and no stale writes appear.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file widths and the writeback request type used by the MDU and the writeback arbiter
package cpu_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular FIFO of writeback requests exposing its storage and a per-slot valid mask
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  wb_req_t       din,
  output wb_req_t       head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output wb_req_t       entries [DEPTH],
  output logic [DEPTH-1:0] valid
);
  logic [AW-1:0] wr, rd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= push ? wr + 1'b1 : wr;
      rd <= pop ? rd + 1'b1 : rd;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) entries[wr] <= din;
  assign head = entries[rd];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  // a slot is live when its distance from the read pointer is below the occupancy
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    assign valid[i] = {1'b0, AW'(i) - rd} < count;
  end
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges the pipeline writeback and queued MDU results into one regfile write port,
// with pending-write hazard reporting and a starvation stall request
module wb_write_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_wr,
  input  logic [REG_AW-1:0]        pipe_dst,
  input  logic [DATA_W-1:0]        pipe_data,
  input  logic                     mdu_valid,
  input  logic [REG_AW-1:0]        mdu_dst,
  input  logic [DATA_W-1:0]        mdu_data,
  output logic                     mdu_ready,
  output logic                     reg_wr,
  output logic [REG_AW-1:0]        reg_dst,
  output logic [DATA_W-1:0]        reg_wd,
  input  logic [REG_AW-1:0]        chk_rs,
  input  logic [REG_AW-1:0]        chk_rt,
  output logic                     rs_pending,
  output logic                     rt_pending,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  wb_req_t din, head;
  wb_req_t entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic full, empty, pipe_ok, pop, push, rs_hit, rt_hit;
  logic [SW-1:0] starve;
  assign pipe_ok = pipe_wr && pipe_dst != REG_ZERO;
  assign pop = rst_n && !pipe_ok && !empty;
  assign mdu_ready = rst_n && !full;
  assign push = mdu_valid && mdu_ready && mdu_dst != REG_ZERO;
  assign din = '{dst: mdu_dst, data: mdu_data};
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .din     (din),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count),
    .entries (entries),
    .valid   (valid)
  );
  always_comb begin
    reg_wr = rst_n && (pipe_ok || !empty);
    reg_dst = !rst_n ? REG_ZERO : pipe_ok ? pipe_dst : pop ? head.dst : REG_ZERO;
    reg_wd = !rst_n ? '0 : pipe_ok ? pipe_data : pop ? head.data : '0;
  end
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rs_hit |= valid[i] && entries[i].dst == chk_rs;
      rt_hit |= valid[i] && entries[i].dst == chk_rt;
    end
    rs_pending = rs_hit && chk_rs != REG_ZERO;
    rt_pending = rt_hit && chk_rt != REG_ZERO;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve <= '0;
    else if (empty || pop) starve <= '0;
    else if (starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
  end
  assign stall_req = rst_n && (starve == SW'(STARVE_MAX) || full);
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed and random stimulus against a queue-based model of the writeback arbiter
module tb_wb_write_arbiter;
  import cpu_pkg::*;
  localparam int DEPTH = 4;
  localparam int SMAX = 8;
  logic clk = 0, rst_n = 0;
  logic pipe_wr = 0, mdu_valid = 0, mdu_ready, reg_wr, rs_pending, rt_pending, stall_req;
  logic [4:0] pipe_dst = 0, mdu_dst = 0, chk_rs = 0, chk_rt = 0, reg_dst;
  logic [31:0] pipe_data = 0, mdu_data = 0, reg_wd;
  logic [2:0] fifo_count;
  int checks = 0, failures = 0, starve = 0;
  wb_req_t q[$];

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_wr(pipe_wr), .pipe_dst(pipe_dst), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_dst(mdu_dst), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .reg_wd(reg_wd), .chk_rs(chk_rs), .chk_rt(chk_rt),
    .rs_pending(rs_pending), .rt_pending(rt_pending), .stall_req(stall_req), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit stall_now();
    return rst_n && (starve == SMAX || q.size() == DEPTH);
  endfunction

  task automatic drive(bit pw, logic [4:0] pd, logic [31:0] pdat, bit mv, logic [4:0] md, logic [31:0] mdat);
    pipe_wr = pw; pipe_dst = pd; pipe_data = pdat;
    mdu_valid = mv; mdu_dst = md; mdu_data = mdat;
  endtask

  // called just after a negedge with inputs set; checks outputs, then advances the model at posedge
  task automatic cycle();
    bit pw, pop, ready, rsp, rt, was_empty, stall;
    logic [4:0] d;
    logic [31:0] w;
    pw = pipe_wr && pipe_dst != 0;
    was_empty = q.size() == 0;
    pop = !pw && !was_empty;
    ready = q.size() < DEPTH;
    d = pw ? pipe_dst : pop ? q[0].dst : 5'd0;
    w = pw ? pipe_data : pop ? q[0].data : 32'd0;
    rsp = 0; rt = 0;
    foreach (q[i]) begin
      rsp |= q[i].dst == chk_rs;
      rt |= q[i].dst == chk_rt;
    end
    rsp &= chk_rs != 0;
    rt &= chk_rt != 0;
    stall = stall_now();
    if (!rst_n) begin pw = 0; pop = 0; ready = 0; d = 0; w = 0; rsp = 0; rt = 0; end
    #1;
    chk("reg_wr", reg_wr, pw || pop);
    chk("reg_dst", reg_dst, d);
    chk("reg_wd", reg_wd, w);
    chk("mdu_ready", mdu_ready, ready);
    chk("fifo_count", fifo_count, q.size());
    chk("stall_req", stall_req, stall);
    chk("rs_pending", rs_pending, rsp);
    chk("rt_pending", rt_pending, rt);
    if (reg_wr) $display("reg:$%0h<=%h", reg_dst, reg_wd);
    @(posedge clk);
    if (rst_n) begin
      if (pop) q.delete(0);
      if (mdu_valid && ready && mdu_dst != 0) q.push_back(wb_req_t'{dst: mdu_dst, data: mdu_data});
      starve = (pop || was_empty) ? 0 : (starve < SMAX ? starve + 1 : starve);
    end else begin
      q.delete();
      starve = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    repeat (2) cycle();
    rst_n = 1;
    // idle, then a direct pipeline write
    cycle();
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0); cycle();
    // MDU results queue behind a busy pipeline, then drain in order
    drive(1, 3, 32'h1, 1, 9, 32'h11); cycle();
    drive(1, 3, 32'h2, 1, 10, 32'h22); cycle();
    chk_rt = 9;
    drive(1, 3, 32'h3, 0, 0, 0); cycle();
    chk("rt_pending_9", rt_pending, 1);
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    // $0 pipe write frees the slot; $0 MDU result is dropped
    drive(1, 3, 32'h4, 1, 4, 32'h44); cycle();
    drive(1, 0, 32'h5, 0, 0, 0); cycle();
    drive(0, 0, 0, 1, 0, 32'h99); cycle();
    drive(0, 0, 0, 0, 0, 0); cycle();
    chk("zero_drop_count", fifo_count, 0);
    // fill the FIFO, hold a fifth result, honour the bubble contract
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 3, i, 1, 5'(16 + i), 32'h100 + i); cycle();
    end
    repeat (4) begin
      drive(!stall_now(), 3, 32'h7, 1, 12, 32'hC0FFEE); cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) cycle();
    // single entry starved by a busy pipeline
    drive(1, 3, 32'h8, 1, 7, 32'h77); cycle();
    for (int k = 1; k <= 9; k++) begin
      drive(1, 3, k, 0, 0, 0); cycle();
    end
    drive(0, 0, 0, 0, 0, 0); cycle();
    cycle();
    // asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1, 3, i, 1, 5'(20 + i), 32'h200 + i); cycle();
    end
    chk_rs = 20;
    #2 rst_n = 0;
    #1;
    chk("async_reg_wr", reg_wr, 0);
    chk("async_ready", mdu_ready, 0);
    chk("async_count", fifo_count, 0);
    chk("async_rs_pending", rs_pending, 0);
    chk("async_stall", stall_req, 0);
    q.delete();
    starve = 0;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    rst_n = 1;
    repeat (3) cycle();
    // randomized traffic respecting the stall contract
    for (int n = 0; n < 400; n++) begin
      drive(!stall_now() && $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      chk_rs = 5'($urandom_range(0, 7));
      chk_rt = 5'($urandom_range(0, 7));
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
